rect_cyl: RTL and testbench



---
 rtl/rect_cyl_pkg.sv | 20 ++
 rtl/rect_cyl_if.sv | 14 +
 rtl/rect_cyl_isqrt.sv | 35 +++
 rtl/rect_cyl.sv | 63 ++++++
 tb/tb_rect_cyl.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/rect_cyl_pkg.sv
// rtl/rect_cyl_pkg.sv - widths, limits and shared helpers for the rect_cyl magnitude unit
package rect_cyl_pkg;

    localparam int IN_W    = 8;
    localparam int SQ_W    = 17;
    localparam int ROOT_W  = 9;
    localparam int REM_W   = 10;
    localparam int OUT_W   = 8;
    localparam int LATENCY = 3;

    localparam logic [OUT_W-1:0] OUT_MAX = 8'd255;

    // Operand is widened first so the product is computed at full 16-bit width.
    function automatic logic [SQ_W-1:0] square(input logic [IN_W-1:0] a);
        logic [2*IN_W-1:0] a_w;
        a_w = {{IN_W{1'b0}}, a};
        return {1'b0, a_w * a_w};
    endfunction

endpackage

// File: rtl/rect_cyl_if.sv
// rtl/rect_cyl_if.sv - pad-side bundle of the rect_cyl block (enable, x/y inputs, r output, bidir enables)
interface rect_cyl_if;
    import rect_cyl_pkg::*;

    logic             ena;
    logic [IN_W-1:0]  ui_in;
    logic [IN_W-1:0]  uio_in;
    logic [OUT_W-1:0] uo_out;
    logic [OUT_W-1:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_oe);

endinterface

// File: rtl/rect_cyl_isqrt.sv
// rtl/rect_cyl_isqrt.sv - combinational restoring integer square root, 17-bit radicand to 9-bit root + 10-bit remainder
module rect_cyl_isqrt
    import rect_cyl_pkg::*;
(
    input  logic [SQ_W-1:0]   s,
    output logic [ROOT_W-1:0] root,
    output logic [REM_W-1:0]  rem
);

    logic [2*ROOT_W-1:0] s_ext;
    logic [REM_W+1:0]    acc;
    logic [REM_W+1:0]    trial;
    logic [ROOT_W-1:0]   q;

    // One root bit per iteration, consuming two radicand bits MSB first.
    always_comb begin
        s_ext = {1'b0, s};
        acc   = '0;
        trial = '0;
        q     = '0;
        for (int i = ROOT_W - 1; i >= 0; i--) begin
            acc   = {acc[REM_W-1:0], s_ext[2*i +: 2]};
            trial = {1'b0, q, 2'b01};
            if (acc >= trial) begin
                acc = acc - trial;
                q   = {q[ROOT_W-2:0], 1'b1};
            end else begin
                q   = {q[ROOT_W-2:0], 1'b0};
            end
        end
        root = q;
        rem  = acc[REM_W-1:0];
    end

endmodule

// File: rtl/rect_cyl.sv
// rtl/rect_cyl.sv - 3-stage pipelined r = sqrt(x*x + y*y); define RECT_CYL_ROUND_EN for round-to-nearest
module rect_cyl
    import rect_cyl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    rect_cyl_if.slave  pads
);

    logic [IN_W-1:0]   xr_q, xr_d;
    logic [IN_W-1:0]   yr_q, yr_d;
    logic [SQ_W-1:0]   s_q, s_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic [ROOT_W-1:0] root;
    logic [ROOT_W-1:0] result;
    logic [REM_W-1:0]  rem;

    rect_cyl_isqrt u_isqrt (
        .s    (s_q),
        .root (root),
        .rem  (rem)
    );

`ifdef RECT_CYL_ROUND_EN
    // (q + 0.5)^2 = q^2 + q + 0.25, so rem > q means the true root is nearer q + 1.
    assign result = (rem > {1'b0, root}) ? root + ROOT_W'(1) : root;
`else
    logic [REM_W-1:0] unused_rem;
    assign unused_rem = rem;
    assign result     = root;
`endif

    always_comb begin
        xr_d  = xr_q;
        yr_d  = yr_q;
        s_d   = s_q;
        out_d = out_q;
        if (pads.ena) begin
            xr_d  = pads.ui_in;
            yr_d  = pads.uio_in;
            s_d   = square(xr_q) + square(yr_q);
            out_d = (result > ROOT_W'(OUT_MAX)) ? OUT_MAX : result[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xr_q  <= '0;
            yr_q  <= '0;
            s_q   <= '0;
            out_q <= '0;
        end else begin
            xr_q  <= xr_d;
            yr_q  <= yr_d;
            s_q   <= s_d;
            out_q <= out_d;
        end
    end

    assign pads.uo_out = out_q;
    assign pads.uio_oe = '0;

endmodule

// File: tb/tb_rect_cyl.sv
// tb/tb_rect_cyl.sv - vector table plus scoreboard bench for rect_cyl (honours RECT_CYL_ROUND_EN)
module tb_rect_cyl;
    import rect_cyl_pkg::*;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] r;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] sbq[$];
    logic [7:0] cur_exp = 8'd0;
    vec_t vecs[13];

    rect_cyl_if pads ();

    rect_cyl dut (
        .clk  (clk),
        .rst  (rst),
        .pads (pads)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] y);
        int s;
        int q;
        s = int'(x) * int'(x) + int'(y) * int'(y);
        q = 0;
        while ((q + 1) * (q + 1) <= s) q++;
`ifdef RECT_CYL_ROUND_EN
        if (4 * s > (2 * q + 1) * (2 * q + 1)) q++;
`endif
        if (q > 255) q = 255;
        return q[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_reset();
        sbq.delete();
        for (int i = 0; i < LATENCY - 1; i++) sbq.push_back(8'd0);
        cur_exp = 8'd0;
    endtask

    // One clock: drive, take the edge, then compare against the scoreboard.
    task automatic tick(input logic [7:0] x, input logic [7:0] y, input logic e, input logic r);
        pads.ui_in  = x;
        pads.uio_in = y;
        pads.ena    = e;
        rst         = r;
        @(posedge clk);
        #1;
        if (r) begin
            sb_reset();
        end else if (e) begin
            sbq.push_back(model(x, y));
            cur_exp = sbq.pop_front();
        end
        check(r ? "reset_out" : (e ? "stream_out" : "frozen_out"), pads.uo_out, cur_exp);
        check("uio_oe", pads.uio_oe, 8'h00);
    endtask

    initial begin
        vecs[0]  = '{8'd3,   8'd4,   8'd5};
        vecs[1]  = '{8'd5,   8'd12,  8'd13};
        vecs[2]  = '{8'd7,   8'd24,  8'd25};
        vecs[3]  = '{8'd200, 8'd150, 8'd250};
        vecs[4]  = '{8'd0,   8'd10,  8'd10};
        vecs[5]  = '{8'd10,  8'd0,   8'd10};
        vecs[6]  = '{8'd0,   8'd0,   8'd0};
        vecs[7]  = '{8'd1,   8'd1,   8'd1};
        vecs[8]  = '{8'd255, 8'd255, 8'd255};
`ifdef RECT_CYL_ROUND_EN
        vecs[9]  = '{8'd2,   8'd3,   8'd4};
        vecs[10] = '{8'd180, 8'd180, 8'd255};
`else
        vecs[9]  = '{8'd2,   8'd3,   8'd3};
        vecs[10] = '{8'd180, 8'd180, 8'd254};
`endif
        vecs[11] = '{8'd255, 8'd0,   8'd255};
        vecs[12] = '{8'd100, 8'd100, 8'd141};

        pads.ena    = 1'b0;
        pads.ui_in  = 8'd0;
        pads.uio_in = 8'd0;
        sb_reset();

        repeat (3) tick(8'd0, 8'd0, 1'b0, 1'b1);
        repeat (4) tick(8'd0, 8'd0, 1'b1, 1'b0);

        foreach (vecs[i]) begin
            repeat (5) tick(vecs[i].x, vecs[i].y, 1'b1, 1'b0);
            check($sformatf("table_%0d_%0d", vecs[i].x, vecs[i].y), pads.uo_out, vecs[i].r);
        end

        // Back-to-back pairs: 5, 10, 13 on consecutive cycles after the fill latency.
        tick(8'd3, 8'd4, 1'b1, 1'b0);
        tick(8'd6, 8'd8, 1'b1, 1'b0);
        tick(8'd5, 8'd12, 1'b1, 1'b0);
        check("stream_first", pads.uo_out, 8'd5);
        tick(8'd0, 8'd0, 1'b1, 1'b0);
        check("stream_second", pads.uo_out, 8'd10);
        tick(8'd0, 8'd0, 1'b1, 1'b0);
        check("stream_third", pads.uo_out, 8'd13);

        // Enable dropped mid-stream: outputs freeze and in-flight data survives.
        tick(8'd7, 8'd24, 1'b1, 1'b0);
        tick(8'd200, 8'd150, 1'b1, 1'b0);
        repeat (4) tick(8'd9, 8'd40, 1'b0, 1'b0);
        tick(8'd5, 8'd12, 1'b1, 1'b0);
        check("resume_first", pads.uo_out, 8'd25);
        tick(8'd0, 8'd0, 1'b1, 1'b0);
        check("resume_second", pads.uo_out, 8'd250);
        tick(8'd0, 8'd0, 1'b1, 1'b0);
        check("resume_third", pads.uo_out, 8'd13);

        // Reset mid-stream discards everything in flight.
        tick(8'd3, 8'd4, 1'b1, 1'b0);
        tick(8'd6, 8'd8, 1'b1, 1'b0);
        tick(8'd60, 8'd80, 1'b1, 1'b1);
        check("midreset_out", pads.uo_out, 8'd0);
        tick(8'd0, 8'd0, 1'b1, 1'b0);
        check("flushed_a", pads.uo_out, 8'd0);
        tick(8'd0, 8'd0, 1'b1, 1'b0);
        check("flushed_b", pads.uo_out, 8'd0);

        for (int k = 0; k < 60; k++) begin
            tick(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) != 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
